// File: rtl/space_pkg.sv
// Shared screen geometry, controller state encoding and coordinate clamp helper
// for the spaceship motion logic.
package space_pkg;

    localparam int SCREEN_CORDW = 16;
    localparam int H_RES        = 640;
    localparam int V_RES        = 480;

    typedef enum logic [1:0] {
        ST_CAL  = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } ctrl_state_t;

    // Clamp a one-bit-wider signed coordinate into [lo, hi] and narrow it.
    function automatic logic signed [SCREEN_CORDW-1:0] clamp_coord(
        input logic signed [SCREEN_CORDW:0] v,
        input logic signed [SCREEN_CORDW:0] lo,
        input logic signed [SCREEN_CORDW:0] hi
    );
        logic signed [SCREEN_CORDW:0] r;
        if (v < lo) begin
            r = lo;
        end else if (v > hi) begin
            r = hi;
        end else begin
            r = v;
        end
        return SCREEN_CORDW'(r);
    endfunction

endpackage

// File: rtl/tilt_axis_step.sv
// One axis of tilt-to-step conversion: offset removal, deadzone, gain shift and
// symmetric saturation. Purely combinational.
module tilt_axis_step #(
    parameter int DATA_W     = 16,
    parameter int STEP_W     = 16,
    parameter int DEADZONE   = 16,
    parameter int GAIN_SHIFT = 4,
    parameter int MAX_STEP   = 8
) (
    input  logic signed [DATA_W-1:0] sample,
    input  logic signed [DATA_W-1:0] offset,
    output logic signed [STEP_W-1:0] step
);

    localparam logic signed [DATA_W:0] DZ_S  = (DATA_W+1)'(DEADZONE);
    localparam logic signed [DATA_W:0] MAX_S = (DATA_W+1)'(MAX_STEP);
    localparam logic signed [DATA_W:0] MIN_S = -(DATA_W+1)'(MAX_STEP);

    logic signed [DATA_W:0] delta_s;
    logic signed [DATA_W:0] abs_delta_s;
    logic signed [DATA_W:0] shifted_s;

    // The delta is one bit wider than the samples so the subtraction cannot wrap.
    always_comb begin
        delta_s     = {sample[DATA_W-1], sample} - {offset[DATA_W-1], offset};
        abs_delta_s = delta_s[DATA_W] ? -delta_s : delta_s;
        shifted_s   = delta_s >>> GAIN_SHIFT;
        if (abs_delta_s <= DZ_S) begin
            step = '0;
        end else if (shifted_s > MAX_S) begin
            step = STEP_W'(MAX_S);
        end else if (shifted_s < MIN_S) begin
            step = STEP_W'(MIN_S);
        end else begin
            step = STEP_W'(shifted_s);
        end
    end

endmodule

// File: rtl/tilt_motion_ctrl.sv
// Tilt-driven spaceship positioning: zero-tilt calibration, two-stage step
// pipeline, and clamped position registers with freeze/recalibrate control.
module tilt_motion_ctrl
    import space_pkg::*;
#(
    parameter int CAL_LOG2   = 3,
    parameter int DEADZONE   = 16,
    parameter int GAIN_SHIFT = 4,
    parameter int MAX_STEP   = 8,
    parameter int X_MIN      = 0,
    parameter int X_MAX      = 606,
    parameter int Y_MIN      = 0,
    parameter int Y_MAX      = 444,
    parameter int INIT_X     = 300,
    parameter int INIT_Y     = 240
) (
    input  logic                           slowclk,
    input  logic                           reset_n,
    input  logic signed [15:0]             data_x,
    input  logic signed [15:0]             data_y,
    input  logic                           sample_valid,
    input  logic                           freeze,
    input  logic                           recal,
    output logic signed [SCREEN_CORDW-1:0] spaceship_x,
    output logic signed [SCREEN_CORDW-1:0] spaceship_y,
    output logic                           cal_done,
    output logic [1:0]                     state
);

    localparam int ACC_W = 16 + CAL_LOG2;
    localparam logic [CAL_LOG2-1:0] CAL_LAST = {CAL_LOG2{1'b1}};
    localparam logic signed [SCREEN_CORDW:0] X_MIN_S = (SCREEN_CORDW+1)'(X_MIN);
    localparam logic signed [SCREEN_CORDW:0] X_MAX_S = (SCREEN_CORDW+1)'(X_MAX);
    localparam logic signed [SCREEN_CORDW:0] Y_MIN_S = (SCREEN_CORDW+1)'(Y_MIN);
    localparam logic signed [SCREEN_CORDW:0] Y_MAX_S = (SCREEN_CORDW+1)'(Y_MAX);

    ctrl_state_t                    state_r;
    logic                           cal_done_r;
    logic signed [ACC_W-1:0]        acc_x_r, acc_y_r;
    logic [CAL_LOG2-1:0]            count_r;
    logic signed [15:0]             off_x_r, off_y_r;
    logic signed [SCREEN_CORDW-1:0] step_x_r, step_y_r;
    logic                           step_valid_r;
    logic signed [SCREEN_CORDW-1:0] pos_x_r, pos_y_r;

    logic signed [ACC_W-1:0]        acc_sum_x_s, acc_sum_y_s;
    logic signed [SCREEN_CORDW-1:0] step_x_s, step_y_s;
    logic signed [SCREEN_CORDW:0]   next_x_s, next_y_s;

    tilt_axis_step #(
        .DATA_W(16), .STEP_W(SCREEN_CORDW), .DEADZONE(DEADZONE),
        .GAIN_SHIFT(GAIN_SHIFT), .MAX_STEP(MAX_STEP)
    ) u_step_x (
        .sample(data_x), .offset(off_x_r), .step(step_x_s)
    );

    tilt_axis_step #(
        .DATA_W(16), .STEP_W(SCREEN_CORDW), .DEADZONE(DEADZONE),
        .GAIN_SHIFT(GAIN_SHIFT), .MAX_STEP(MAX_STEP)
    ) u_step_y (
        .sample(data_y), .offset(off_y_r), .step(step_y_s)
    );

    // Running calibration sums and unclamped next positions; y subtracts so positive tilt moves up.
    always_comb begin
        acc_sum_x_s = acc_x_r + {{CAL_LOG2{data_x[15]}}, data_x};
        acc_sum_y_s = acc_y_r + {{CAL_LOG2{data_y[15]}}, data_y};
        next_x_s    = {pos_x_r[SCREEN_CORDW-1], pos_x_r} + {step_x_r[SCREEN_CORDW-1], step_x_r};
        next_y_s    = {pos_y_r[SCREEN_CORDW-1], pos_y_r} - {step_y_r[SCREEN_CORDW-1], step_y_r};
    end

    // Controller FSM with calibration, step pipeline and position registers.
    always_ff @(posedge slowclk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_CAL;
            cal_done_r   <= 1'b0;
            acc_x_r      <= '0;
            acc_y_r      <= '0;
            count_r      <= '0;
            off_x_r      <= 16'sd0;
            off_y_r      <= 16'sd0;
            step_x_r     <= '0;
            step_y_r     <= '0;
            step_valid_r <= 1'b0;
            pos_x_r      <= SCREEN_CORDW'(INIT_X);
            pos_y_r      <= SCREEN_CORDW'(INIT_Y);
        end else if (recal) begin
            state_r      <= ST_CAL;
            cal_done_r   <= 1'b0;
            acc_x_r      <= '0;
            acc_y_r      <= '0;
            count_r      <= '0;
            step_valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_CAL: begin
                    step_valid_r <= 1'b0;
                    if (sample_valid) begin
                        if (count_r == CAL_LAST) begin
                            off_x_r    <= 16'(acc_sum_x_s >>> CAL_LOG2);
                            off_y_r    <= 16'(acc_sum_y_s >>> CAL_LOG2);
                            acc_x_r    <= '0;
                            acc_y_r    <= '0;
                            count_r    <= '0;
                            cal_done_r <= 1'b1;
                            state_r    <= ST_RUN;
                        end else begin
                            acc_x_r <= acc_sum_x_s;
                            acc_y_r <= acc_sum_y_s;
                            count_r <= count_r + 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (freeze) begin
                        state_r      <= ST_HOLD;
                        step_valid_r <= 1'b0;
                    end else begin
                        step_valid_r <= sample_valid;
                        step_x_r     <= step_x_s;
                        step_y_r     <= step_y_s;
                        if (step_valid_r) begin
                            pos_x_r <= clamp_coord(next_x_s, X_MIN_S, X_MAX_S);
                            pos_y_r <= clamp_coord(next_y_s, Y_MIN_S, Y_MAX_S);
                        end
                    end
                end
                ST_HOLD: begin
                    step_valid_r <= 1'b0;
                    if (!freeze) begin
                        state_r <= ST_RUN;
                    end else begin
                        state_r <= ST_HOLD;
                    end
                end
                default: begin
                    state_r      <= ST_CAL;
                    cal_done_r   <= 1'b0;
                    step_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign spaceship_x = pos_x_r;
    assign spaceship_y = pos_y_r;
    assign cal_done    = cal_done_r;
    assign state       = state_r;

endmodule

// File: tb/tb_tilt_motion_ctrl.sv
// Directed bench for tilt_motion_ctrl: calibration, stepping, saturation,
// clamping, deadzone, freeze, recalibration and async reset.
module tb_tilt_motion_ctrl;

    logic               slowclk = 1'b0;
    logic               reset_n = 1'b0;
    logic signed [15:0] data_x  = 16'sd0;
    logic signed [15:0] data_y  = 16'sd0;
    logic               sample_valid = 1'b0;
    logic               freeze  = 1'b0;
    logic               recal   = 1'b0;
    logic signed [15:0] spaceship_x;
    logic signed [15:0] spaceship_y;
    logic               cal_done;
    logic [1:0]         state;

    int total = 0;
    int bad   = 0;

    tilt_motion_ctrl dut (
        .slowclk(slowclk), .reset_n(reset_n), .data_x(data_x), .data_y(data_y),
        .sample_valid(sample_valid), .freeze(freeze), .recal(recal),
        .spaceship_x(spaceship_x), .spaceship_y(spaceship_y),
        .cal_done(cal_done), .state(state)
    );

    always #5 slowclk = ~slowclk;

    task automatic tick();
        @(posedge slowclk);
        #1;
    endtask

    task automatic sample(input logic signed [15:0] x, input logic signed [15:0] y);
        data_x = x;
        data_y = y;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic check_all(input string name, input logic signed [15:0] ex,
                             input logic signed [15:0] ey, input logic [1:0] est,
                             input logic ecd);
        total++;
        if (spaceship_x !== ex || spaceship_y !== ey || state !== est || cal_done !== ecd) begin
            bad++;
            $display("FAIL %s: got x=%0d y=%0d state=%0d cal_done=%0b, want x=%0d y=%0d state=%0d cal_done=%0b",
                     name, spaceship_x, spaceship_y, state, cal_done, ex, ey, est, ecd);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick();
        tick();
        total++;
        if (spaceship_x !== 16'sd300 || spaceship_y !== 16'sd240 || state !== 2'd0 || cal_done !== 1'b0) begin
            bad++;
            $display("FAIL reset: got x=%0d y=%0d state=%0d cal_done=%0b, want 300 240 0 0",
                     spaceship_x, spaceship_y, state, cal_done);
        end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_calibrate();
        for (int i = 0; i < 7; i++) sample(16'sd20, -16'sd12);
        check_all("cal_after7", 16'sd300, 16'sd240, 2'd0, 1'b0);
        sample(16'sd20, -16'sd12);
        check_all("cal_after8", 16'sd300, 16'sd240, 2'd1, 1'b1);
    endtask

    task automatic test_step();
        sample(16'sd100, -16'sd12);
        check_all("step_latency", 16'sd300, 16'sd240, 2'd1, 1'b1);
        tick();
        check_all("step_move", 16'sd305, 16'sd240, 2'd1, 1'b1);
    endtask

    task automatic test_saturate_clamp();
        data_x = 16'sd420;
        data_y = 16'sd500;
        sample_valid = 1'b1;
        tick();
        tick();
        check_all("sat_first_step", 16'sd313, 16'sd232, 2'd1, 1'b1);
        for (int i = 0; i < 58; i++) tick();
        sample_valid = 1'b0;
        tick();
        check_all("clamp_xmax_ymin", 16'sd606, 16'sd0, 2'd1, 1'b1);
    endtask

    task automatic test_deadzone();
        sample(16'sd36, -16'sd12);
        tick();
        check_all("deadzone_edge", 16'sd606, 16'sd0, 2'd1, 1'b1);
        sample(16'sd3, -16'sd12);
        tick();
        check_all("floor_neg", 16'sd604, 16'sd0, 2'd1, 1'b1);
    endtask

    task automatic test_freeze();
        freeze = 1'b1;
        data_x = 16'sd100;
        data_y = -16'sd12;
        sample_valid = 1'b1;
        tick();
        tick();
        tick();
        check_all("freeze_hold", 16'sd604, 16'sd0, 2'd2, 1'b1);
        freeze = 1'b0;
        sample_valid = 1'b0;
        tick();
        check_all("unfreeze_run", 16'sd604, 16'sd0, 2'd1, 1'b1);
        sample(-16'sd300, -16'sd12);
        tick();
        check_all("resume_move", 16'sd596, 16'sd0, 2'd1, 1'b1);
    endtask

    task automatic test_recal();
        sample(16'sd100, -16'sd12);
        recal = 1'b1;
        tick();
        recal = 1'b0;
        tick();
        check_all("recal_no_move", 16'sd596, 16'sd0, 2'd0, 1'b0);
        for (int i = 0; i < 8; i++) sample(16'sd0, 16'sd0);
        check_all("recal_done", 16'sd596, 16'sd0, 2'd1, 1'b1);
        sample(16'sd100, -16'sd20);
        tick();
        check_all("new_offset", 16'sd602, 16'sd2, 2'd1, 1'b1);
    endtask

    task automatic test_async_reset();
        sample(16'sd200, 16'sd0);
        #2;
        reset_n = 1'b0;
        #1;
        check_all("async_reset", 16'sd300, 16'sd240, 2'd0, 1'b0);
        tick();
        reset_n = 1'b1;
        tick();
        check_all("post_reset", 16'sd300, 16'sd240, 2'd0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_calibrate();
        test_step();
        test_saturate_clamp();
        test_deadzone();
        test_freeze();
        test_recal();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
